// File: rtl/systolic_feeder_pkg.sv
// -----------------------------------------------------------------------------
// systolic_feeder_pkg
//   Shared types and sizing helpers for the systolic row feeder.
//   - state_t    : feeder control states (IDLE, LOADED, SHIFT)
//   - chunks()   : number of N-bit chunks in an S-bit word
//   - cnt_width(): bits needed to hold the values 0..max_val
// -----------------------------------------------------------------------------
package systolic_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      SHIFT  = 2'd2
   } state_t;

   function automatic int chunks(input int s, input int n);
      return s / n;
   endfunction

   // Always at least one bit, even for a degenerate range.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/systolic_feeder_lane.sv
// -----------------------------------------------------------------------------
// systolic_feeder_lane
//   One row of the feeder: an S-bit operand register that emits its word
//   LSB-first, N bits per enabled cycle, through a registered chunk output.
//   Optional feature macro: RING_RECIRC_EN
//     defined   : the word rotates right by N (emitted chunk re-enters at MSB),
//                 so after S/N shifts the original word is restored.
//     undefined : logical right shift by N with zero fill.
//
//   Ports
//     clk       in  1  clock
//     clear     in  1  synchronous clear of word and chunk registers
//     load_en   in  1  capture load_data into the word register
//     shift_en  in  1  emit the low chunk and advance the word by N
//     load_data in  S  operand word
//     chunk     out N  registered chunk; 0 whenever shift_en was low
// -----------------------------------------------------------------------------
module systolic_feeder_lane
   import systolic_feeder_pkg::*;
#(
   parameter int S = 8,
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         load_en,
   input  logic         shift_en,
   input  logic [S-1:0] load_data,
   output logic [N-1:0] chunk
);

   localparam int C = chunks(S, N);

   logic [S-1:0] word;
   logic [S-1:0] next_word;

   // With a single chunk per word there are no upper bits to move down,
   // so that case is handled separately to avoid an empty part-select.
   generate
      if (C == 1) begin : g_single
`ifdef RING_RECIRC_EN
         assign next_word = word;
`else
         assign next_word = '0;
`endif
      end else begin : g_multi
`ifdef RING_RECIRC_EN
         assign next_word = {word[N-1:0], word[S-1:N]};
`else
         assign next_word = {{N{1'b0}}, word[S-1:N]};
`endif
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of word, independent of statement order.
   always_ff @(posedge clk) begin
      if (clear) begin
         word  <= '0;
         chunk <= '0;
      end else begin
         if (load_en)
            word <= load_data;
         else if (shift_en)
            word <= next_word;
         chunk <= shift_en ? word[N-1:0] : '0;
      end
   end

endmodule

// File: rtl/systolic_row_feeder.sv
// -----------------------------------------------------------------------------
// systolic_row_feeder
//   Loads one S-bit operand word per array row and streams each word
//   LSB-first as N-bit chunks; row r starts r cycles after row 0, producing
//   the diagonal wavefront the systolic array consumes.
//   Optional feature macro: RING_RECIRC_EN
//     defined   : rows rotate, pass ends in LOADED so start can replay.
//     undefined : rows zero-fill, pass ends in IDLE and a new load is needed.
//
//   Ports
//     clk       in  1       clock
//     rst       in  1       synchronous active-high reset
//     load      in  1       capture in_data (IDLE, or LOADED without start)
//     in_data   in  ROWS*S  row r word at [r*S +: S]
//     start     in  1       begin a streaming pass (LOADED only)
//     shift_out out ROWS*N  row r chunk at [r*N +: N], registered
//     out_valid out ROWS    bit r high when row r carries a real chunk
//     busy      out 1       high while in SHIFT
//     done      out 1       one-cycle pulse after a pass completes
// -----------------------------------------------------------------------------
module systolic_row_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int S    = 8,
   parameter int N    = 2,
   parameter int ROWS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ROWS*S-1:0] in_data,
   input  logic              start,
   output logic [ROWS*N-1:0] shift_out,
   output logic [ROWS-1:0]   out_valid,
   output logic              busy,
   output logic              done
);

   localparam int C    = chunks(S, N);
   localparam int PASS = C + ROWS - 1;
   // cnt runs 0..PASS-1 while chunks flow, then sits at PASS for the
   // wrap-up edge that clears the outputs and pulses done.
   localparam int CW   = cnt_width(PASS);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [ROWS-1:0] active;
   logic            load_fire;

   // start has priority over load in LOADED; load is ignored in SHIFT.
   always_comb begin
      load_fire = load && ((state == IDLE) || ((state == LOADED) && !start));
   end

   // Row r is active for cnt in [r, r+C); at cnt == PASS no row qualifies.
   // NOTE: every always_comb output gets a default first so no latch forms.
   always_comb begin
      active = '0;
      if (state == SHIFT) begin
         for (int r = 0; r < ROWS; r++) begin
            active[r] = (int'(cnt) >= r) && (int'(cnt) < r + C);
         end
      end
   end

   generate
      for (genvar r = 0; r < ROWS; r++) begin : g_lane
         systolic_feeder_lane #(
            .S (S),
            .N (N)
         ) u_lane (
            .clk       (clk),
            .clear     (rst),
            .load_en   (load_fire),
            .shift_en  (active[r]),
            .load_data (in_data[r*S +: S]),
            .chunk     (shift_out[r*N +: N])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done      <= 1'b0;
         out_valid <= active;
         case (state)
            IDLE: begin
               if (load)
                  state <= LOADED;
            end
            LOADED: begin
               if (start) begin
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt == CW'(PASS)) begin
                  cnt  <= '0;
                  busy <= 1'b0;
                  done <= 1'b1;
`ifdef RING_RECIRC_EN
                  state <= LOADED;
`else
                  state <= IDLE;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
